// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
//
// Shared definitions for the cache request issuer slice: the issuer state
// type, the default data width and the width of the completion counter.
// Imported by the interface, the input FIFO and the top-level issuer.
// ---------------------------------------------------------------------------
package cache_pkg;

   // Default request/response data width in bits.
   localparam int DEFAULT_WIDTH = 8;

   // Default number of input FIFO entries (power of two, at least 2).
   localparam int DEFAULT_DEPTH = 4;

   // Width of the completed-transaction counter; it wraps naturally.
   localparam int DONE_W = 8;

   // Issuer states:
   //   IDLE  - nothing in flight, waiting for the FIFO to hold a request
   //   ISSUE - set_request is presented to the cache set for one cycle
   //   WAIT  - the cache set response is captured this cycle
   //   HOLD  - response is held downstream until it is accepted
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/cache_request_issuer_if.sv
// ---------------------------------------------------------------------------
// cache_request_issuer_if
//
// Bundles the upstream request handshake, the cache set request/response
// pair, the downstream response handshake and the status outputs of the
// cache request issuer.
//
// Signals:
//   in_valid / in_ready / in_data      upstream request handshake
//   set_request / set_response         cache set request and its response
//   out_valid / out_ready / out_data   downstream response handshake
//   busy                               issuer has work pending or in flight
//   done_count                         completed-transaction counter
//
// Modports:
//   slave  - view of the issuer itself
//   master - view of the surrounding environment (upstream, cache set and
//            downstream consumer)
// ---------------------------------------------------------------------------
interface cache_request_issuer_if
   import cache_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;

   logic [WIDTH-1:0]  set_request;
   logic [WIDTH-1:0]  set_response;

   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;

   logic              busy;
   logic [DONE_W-1:0] done_count;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output set_request,
      input  set_response,
      output out_valid,
      input  out_ready,
      output out_data,
      output busy,
      output done_count
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  set_request,
      output set_response,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  busy,
      input  done_count
   );

endinterface

// File: rtl/cache_req_fifo.sv
// ---------------------------------------------------------------------------
// cache_req_fifo
//
// Small first-word-fall-through FIFO holding accepted requests until the
// issuer is free to send them to the cache set.  Pointers wrap naturally
// because DEPTH is a power of two; the occupancy count is one bit wider than
// the pointers so that "full" and "empty" are distinguishable.
//
// Ports:
//   clock  - single clock, all state updates on the rising edge
//   clear  - synchronous active-high reset, overrides push and pop
//   push   - write wdata (ignored while full)
//   pop    - discard the head entry (ignored while empty)
//   wdata  - data to write
//   rdata  - current head entry, valid whenever empty is low
//   full   - registered full flag
//   empty  - no entries stored
// ---------------------------------------------------------------------------
module cache_req_fifo
   import cache_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             full_q,   full_d;

   logic push_en;
   logic pop_en;

   // Writes are refused while full and reads while empty, so the pointers
   // and count can never run past the storage.
   assign push_en = push && !full_q;
   assign pop_en  = pop && !empty;

   assign empty = (count_q == '0);
   assign full  = full_q;
   assign rdata = mem_q[rd_ptr_q];

   // Next pointers, occupancy and full flag.  A simultaneous accepted push
   // and pop leaves the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push_en) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push_en, pop_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      full_d = (count_d == CNT_W'(DEPTH));
   end

   // Control state; clear returns the FIFO to empty regardless of push/pop.
   always_ff @(posedge clock) begin
      if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   // Storage needs no reset: entries are only read once the count says they
   // were written after the last clear.
   always_ff @(posedge clock) begin
      if (!clear && push_en) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/cache_request_issuer.sv
// ---------------------------------------------------------------------------
// cache_request_issuer
//
// Accepts requests from upstream into a small FIFO and issues them one at a
// time to a cache set.  Each request is presented on set_request for one
// ISSUE cycle, the cache set answers one cycle later, the answer is captured
// in WAIT and held on out_data in HOLD until downstream accepts it.  Only one
// request is ever outstanding at the cache set, so responses leave in the
// same order requests were accepted.
//
// Ports:
//   clock  - single clock, all state updates on the rising edge
//   clear  - synchronous active-high reset
//   bus    - cache_request_issuer_if.slave:
//              in_valid/in_ready/in_data     upstream request handshake
//              set_request (registered)      request to the cache set
//              set_response                  registered cache set answer
//              out_valid/out_ready/out_data  downstream response (registered)
//              busy                          state not IDLE or FIFO non-empty
//              done_count                    completed transactions, wrapping
// ---------------------------------------------------------------------------
module cache_request_issuer
   import cache_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                    clock,
   input  logic                    clear,
   cache_request_issuer_if.slave   bus
);

   state_e            state_q,       state_d;
   logic [WIDTH-1:0]  set_request_q, set_request_d;
   logic [WIDTH-1:0]  out_data_q,    out_data_d;
   logic              out_valid_q,   out_valid_d;
   logic [DONE_W-1:0] done_count_q,  done_count_d;

   logic             fifo_push;
   logic             fifo_pop;
   logic [WIDTH-1:0] fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic             in_ready;

   // in_ready depends only on the FIFO's registered full flag, keeping
   // out_ready and the FSM out of the upstream ready path.
   assign in_ready  = !fifo_full;
   assign fifo_push = bus.in_valid && in_ready;

   cache_req_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .clear (clear),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (bus.in_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state and output register logic.  set_request only changes when a
   // new request is popped, so it holds its last issued value everywhere
   // else.  A completed handshake in HOLD can chain straight into the next
   // ISSUE, which gives one transaction every three cycles when downstream
   // is always ready.
   always_comb begin
      state_d       = state_q;
      set_request_d = set_request_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      done_count_d  = done_count_q;
      fifo_pop      = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop      = 1'b1;
               set_request_d = fifo_rdata;
               state_d       = ISSUE;
            end
         end

         ISSUE: begin
            state_d = WAIT;
         end

         WAIT: begin
            out_data_d  = bus.set_response;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end

         HOLD: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d  = 1'b0;
               done_count_d = done_count_q + DONE_W'(1);
               if (!fifo_empty) begin
                  fifo_pop      = 1'b1;
                  set_request_d = fifo_rdata;
                  state_d       = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.  clear wins over any handshake in the same
   // cycle, so a transaction cut short never reaches done_count.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q       <= IDLE;
         set_request_q <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         done_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         set_request_q <= set_request_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         done_count_q  <= done_count_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.set_request = set_request_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.done_count  = done_count_q;
   assign bus.busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_cache_request_issuer.sv
// ---------------------------------------------------------------------------
// tb_cache_request_issuer
//
// Drives requests into cache_request_issuer, models the cache set as a
// registered inverter, and scores every downstream response against a queue
// of expected values filled as requests are accepted.
// ---------------------------------------------------------------------------
module tb_cache_request_issuer;

   logic clock = 1'b0;
   logic clear;

   int checkCount = 0;
   int passCount  = 0;
   int cycleCnt   = 0;

   logic [7:0] expQ[$];
   int         expDone    = 0;
   bit         streamMode = 1'b0;
   int         prevHs     = -1;

   always #5 clock = ~clock;

   cache_request_issuer_if #(.WIDTH(8)) bus ();

   cache_request_issuer #(
      .WIDTH (8),
      .DEPTH (4)
   ) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   // Cache set model: registered inverted echo of the request.
   always @(posedge clock) begin
      bus.set_response <= clear ? 8'h00 : ~bus.set_request;
   end

   always @(posedge clock) begin
      cycleCnt <= cycleCnt + 1;
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Scoreboard: handshakes seen mid-cycle complete on the next rising edge.
   // Responses are scored first, then newly accepted requests are queued.
   always @(negedge clock) begin
      if (clear) begin
         expQ.delete();
         expDone = 0;
         prevHs  = -1;
      end else begin
         if (!streamMode) begin
            prevHs = -1;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("resp_unexpected", 32'(expQ.size()), 32'd1);
            end else begin
               checkOutput("resp_data", {24'h0, bus.out_data}, {24'h0, expQ.pop_front()});
            end
            expDone = (expDone + 1) % 256;
            if (streamMode) begin
               if (prevHs >= 0) begin
                  checkOutput("stream_spacing", 32'(cycleCnt - prevHs), 32'd3);
               end
               prevHs = cycleCnt;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            expQ.push_back(~bus.in_data);
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Present one request and let exactly one edge accept it; in_valid is
   // left high so back-to-back calls form a burst.
   task automatic applyStimulus(input logic [7:0] d);
      int w = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && w < 100) begin
         @(posedge clock);
         #1;
         w++;
      end
      if (!bus.in_ready) begin
         checkOutput("push_timeout", 32'(bus.in_ready), 32'd1);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic drainResponses();
      int w = 0;
      while ((expQ.size() != 0 || bus.out_valid) && w < 2000) begin
         @(posedge clock);
         #1;
         w++;
      end
      checkOutput("drain", 32'(expQ.size()), 32'd0);
   endtask

   task automatic doReset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      clear         = 1'b1;
      waitCycles(1);
      clear         = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;

      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;
      clear         = 1'b1;
      waitCycles(2);

      // Reset state
      checkOutput("rst_out_valid",   32'(bus.out_valid),   32'd0);
      checkOutput("rst_out_data",    32'(bus.out_data),    32'd0);
      checkOutput("rst_set_request", 32'(bus.set_request), 32'd0);
      checkOutput("rst_done_count",  32'(bus.done_count),  32'd0);
      checkOutput("rst_busy",        32'(bus.busy),        32'd0);
      clear = 1'b0;
      checkOutput("rst_in_ready",    32'(bus.in_ready),    32'd1);

      // Single request
      $display("[TB] single request");
      applyStimulus(8'h3C);
      bus.in_valid = 1'b0;
      checkOutput("single_busy", 32'(bus.busy), 32'd1);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
         if (lat == 1) begin
            checkOutput("issue_req", 32'(bus.set_request), 32'h3C);
         end
      end
      checkOutput("latency", 32'(lat), 32'd3);
      checkOutput("single_data", 32'(bus.out_data), 32'hC3);
      checkOutput("hold_req", 32'(bus.set_request), 32'h3C);
      waitCycles(2);
      checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_data",  32'(bus.out_data),  32'hC3);
      bus.out_ready = 1'b1;
      waitCycles(1);
      bus.out_ready = 1'b0;
      checkOutput("single_done",  32'(bus.done_count), 32'd1);
      checkOutput("single_drop",  32'(bus.out_valid),  32'd0);
      checkOutput("idle_busy",    32'(bus.busy),       32'd0);
      checkOutput("idle_req",     32'(bus.set_request), 32'h3C);

      // Burst with backpressure
      $display("[TB] burst with backpressure");
      for (int i = 1; i <= 5; i++) begin
         checkOutput("burst_ready", 32'(bus.in_ready), 32'd1);
         applyStimulus(8'(i));
      end
      checkOutput("burst_full", 32'(bus.in_ready), 32'd0);
      waitCycles(3);
      bus.in_valid = 1'b0;
      checkOutput("burst_still_full", 32'(bus.in_ready),  32'd0);
      checkOutput("burst_hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("burst_hold_data",  32'(bus.out_data),  32'hFE);
      bus.out_ready = 1'b1;
      drainResponses();
      bus.out_ready = 1'b0;
      checkOutput("burst_done", 32'(bus.done_count), 32'd6);

      // Streaming with out_ready tied high
      $display("[TB] streaming");
      doReset();
      checkOutput("reset_done", 32'(bus.done_count), 32'd0);
      streamMode    = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(8'h10 + 8'(i));
      end
      bus.in_valid = 1'b0;
      drainResponses();
      streamMode = 1'b0;
      checkOutput("stream_done", 32'(bus.done_count), 32'd6);

      // Reset in the middle of a transaction
      $display("[TB] clear during WAIT");
      bus.out_ready = 1'b0;
      applyStimulus(8'hAA);
      bus.in_valid = 1'b0;
      waitCycles(2);
      checkOutput("wait_valid", 32'(bus.out_valid), 32'd0);
      clear = 1'b1;
      waitCycles(1);
      clear = 1'b0;
      checkOutput("mid_out_valid",   32'(bus.out_valid),   32'd0);
      checkOutput("mid_out_data",    32'(bus.out_data),    32'd0);
      checkOutput("mid_set_request", 32'(bus.set_request), 32'd0);
      checkOutput("mid_done_count",  32'(bus.done_count),  32'd0);
      checkOutput("mid_busy",        32'(bus.busy),        32'd0);
      checkOutput("mid_in_ready",    32'(bus.in_ready),    32'd1);
      waitCycles(4);
      checkOutput("mid_no_resp", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;
      applyStimulus(8'h0F);
      bus.in_valid = 1'b0;
      drainResponses();
      checkOutput("mid_after_done", 32'(bus.done_count), 32'd1);

      // Counter wrap
      $display("[TB] counter wrap");
      doReset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(8'(i));
      end
      bus.in_valid = 1'b0;
      drainResponses();
      checkOutput("wrap_done", 32'(bus.done_count), 32'd0);
      checkOutput("wrap_model", 32'(bus.done_count), 32'(expDone));
      applyStimulus(8'h5A);
      bus.in_valid = 1'b0;
      drainResponses();
      checkOutput("wrap_next", 32'(bus.done_count), 32'd1);
      bus.out_ready = 1'b0;
      waitCycles(2);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/cache_request_issuer.md
CACHE_REQUEST_ISSUER -- requirements
Module: cache_request_issuer

Interface
REQ-001 Parameter WIDTH, default 8: request/response data width in bits.
REQ-002 Parameter DEPTH, default 4: input FIFO entries; power of two, at least 2.
REQ-003 Port clock, input, 1: single clock; all state updates on posedge.
REQ-004 Port clear, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: upstream request valid.
REQ-006 Port in_ready, output, 1: block can accept a request.
REQ-007 Port in_data, input, WIDTH: upstream request payload.
REQ-008 Port set_request, output, WIDTH: drives the cache set interface request; registered.
REQ-009 Port set_response, input, WIDTH: cache set response; the set registers it one cycle after it samples set_request.
REQ-010 Port out_valid, output, 1: response available downstream.
REQ-011 Port out_ready, input, 1: downstream accepts the response.
REQ-012 Port out_data, output, WIDTH: captured response; registered.
REQ-013 Port busy, output, 1: high whenever state is not IDLE or the FIFO is non-empty.
REQ-014 Port done_count, output, 8: completed-transaction counter.

Function
REQ-015 Push occurs when in_valid and in_ready are both high at a posedge; in_ready SHALL equal !full from registered occupancy, with no combinational path from out_ready or the state machine.
REQ-016 The FIFO SHALL be DEPTH entries with wrapping read/write pointers and a count of width log2(DEPTH)+1; when not full, a simultaneous push and pop leaves the count unchanged.
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT, HOLD.
REQ-018 IDLE: if the FIFO is non-empty, pop the head into set_request and go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE: lasts exactly one cycle, with set_request stable; next state is WAIT.
REQ-020 WAIT: capture set_response into out_data, set out_valid, and go to HOLD.
REQ-021 HOLD: out_valid stays high and out_data stays stable until out_valid && out_ready.
REQ-022 On the HOLD handshake: clear out_valid and increment done_count, wrapping 8'hFF to 8'h00. Then, if the FIFO is non-empty, pop into set_request and go to ISSUE; else go to IDLE.
REQ-023 set_request SHALL hold its last issued value in IDLE, WAIT and HOLD.
REQ-024 Latency: a request pushed at edge E into an empty, IDLE block SHALL produce out_valid in the cycle after edge E+3 (4 cycles).
REQ-025 Throughput: with out_ready held high, one transaction completes every 3 cycles.
REQ-026 At most one request is outstanding at the cache set at any time.
REQ-027 Response ordering SHALL equal request acceptance order.

Reset
REQ-028 When clear is high at a posedge: state goes to IDLE; FIFO count, pointers and full flag go to 0; set_request, out_data and done_count go to 0; out_valid goes to 0.
REQ-029 clear SHALL override every simultaneous push, pop or handshake in the same cycle.
REQ-030 clear mid-transaction (ISSUE/WAIT/HOLD) SHALL discard the transaction without incrementing done_count.
REQ-031 in_ready SHALL be 1 in the first cycle after clear deasserts.

Structure
REQ-032 The shared package cache_pkg SHALL hold the state enum type (IDLE, ISSUE, WAIT, HOLD) and the default WIDTH constant.
REQ-033 The FIFO SHALL be a sub-module, cache_req_fifo, with parameters WIDTH and DEPTH, ports clock, clear, push, pop, wdata, rdata, full, empty, and first-word-fall-through rdata.
REQ-034 The top level SHALL contain only the FSM, the output registers and the counter.

Verification
REQ-035 The bench SHALL model the cache set as response <= clear ? 0 : ~request, registered.
REQ-036 Single request: push 8'h3C into an idle block -> set_request = 8'h3C in ISSUE; out_valid rises 4 cycles after the push with out_data = 8'hC3; done_count = 1 after the handshake.
REQ-037 Burst with backpressure: push 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 with out_ready low -> in_ready drops after 5 accepted (4 in FIFO plus 1 in flight); release out_ready -> responses 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA in order.
REQ-038 Streaming: 6 requests with out_ready tied high -> out_valid pulses every 3 cycles; done_count = 6.
REQ-039 Reset mid-operation: assert clear during WAIT of 8'hAA -> no output for 8'hAA; all outputs 0 next cycle; a subsequent push of 8'h0F returns 8'hF0.
REQ-040 Counter wrap: 256 transactions -> done_count returns to 8'h00; the 257th transaction yields 8'h01.
